// File: rtl/spi_req_sched.sv
// spi_req_sched: round-robin scheduler that shares one APB4 SPI controller
// among NUM_REQ clients. Each granted request runs a fixed APB sequence:
// select CS, push TX, set length, start, poll for completion, pop RX.
module spi_req_sched #(
    parameter int          NUM_REQ    = 4,
    parameter int          POLL_MAX   = 1024,
    parameter logic [31:0] ADDR_CTRL1 = 32'h00,
    parameter logic [31:0] ADDR_CTRL2 = 32'h04,
    parameter logic [31:0] ADDR_DIV   = 32'h08,
    parameter logic [31:0] ADDR_TRL   = 32'h0C,
    parameter logic [31:0] ADDR_TXR   = 32'h10,
    parameter logic [31:0] ADDR_RXR   = 32'h14
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [7:0]            cfg_ctrl1_i,
    input  logic [7:0]            cfg_div_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ*4-1:0]  req_nss_i,
    input  logic [NUM_REQ*32-1:0] req_data_i,
    output logic [NUM_REQ-1:0]    rsp_valid_o,
    output logic [31:0]           rsp_data_o,
    output logic                  rsp_err_o,
    output logic                  busy_o,
    output logic [31:0]           paddr_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [31:0]           pwdata_o,
    input  logic [31:0]           prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(POLL_MAX + 1);

    typedef enum logic [3:0] {
        S_INIT_C1, S_INIT_DIV, S_IDLE, S_SET_CS, S_WR_TX,
        S_WR_TRL, S_START, S_POLL, S_RD_RX, S_RESP
    } state_t;

    state_t        state, state_n;
    logic          psel, psel_n, penable, penable_n, pwrite, pwrite_n;
    logic [31:0]   paddr, paddr_n, pwdata, pwdata_n;
    logic [PW-1:0] rr_ptr, rr_ptr_n, grant, grant_n;
    logic [3:0]    nss, nss_n;
    logic [31:0]   data, data_n;
    logic [CW-1:0] poll_cnt, poll_cnt_n;
    logic [31:0]   rsp_data, rsp_data_n;
    logic          rsp_err, rsp_err_n;

    logic          gnt_any;
    logic [PW-1:0] gnt_idx;
    int            scan;

    logic          xfer_en, xfer_wr;
    logic [31:0]   xfer_addr, xfer_wdata;
    logic          done;

    assign done = psel & penable & pready_i;

    // Round-robin pick: scan from the highest offset down so the lowest
    // offset from rr_ptr (the first valid one) is the value left standing.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        scan    = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            scan = (int'(rr_ptr) + i) % NUM_REQ;
            if (req_valid_i[scan]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(scan);
            end
        end
    end

    // APB access each state performs; CTRL2 keeps en=1, ints off, csv=0.
    always_comb begin
        xfer_en    = 1'b1;
        xfer_wr    = 1'b1;
        xfer_addr  = 32'd0;
        xfer_wdata = 32'd0;
        case (state)
            S_INIT_C1:  begin xfer_addr = ADDR_CTRL1; xfer_wdata = {24'd0, cfg_ctrl1_i}; end
            S_INIT_DIV: begin xfer_addr = ADDR_DIV;   xfer_wdata = {24'd0, cfg_div_i};   end
            S_SET_CS:   begin xfer_addr = ADDR_CTRL2; xfer_wdata = {23'd0, 1'b0, nss, 1'b0, 1'b1, 2'b00}; end
            S_WR_TX:    begin xfer_addr = ADDR_TXR;   xfer_wdata = data; end
            S_WR_TRL:   begin xfer_addr = ADDR_TRL;   xfer_wdata = 32'd1; end
            S_START:    begin xfer_addr = ADDR_CTRL2; xfer_wdata = {23'd0, 1'b0, nss, 1'b1, 1'b1, 2'b00}; end
            S_POLL:     begin xfer_addr = ADDR_CTRL2; xfer_wr = 1'b0; end
            S_RD_RX:    begin xfer_addr = ADDR_RXR;   xfer_wr = 1'b0; end
            default:    xfer_en = 1'b0;
        endcase
    end

    // Next-state, APB phase sequencing (idle -> setup -> access) and capture.
    always_comb begin
        state_n     = state;
        psel_n      = psel;
        penable_n   = penable;
        pwrite_n    = pwrite;
        paddr_n     = paddr;
        pwdata_n    = pwdata;
        rr_ptr_n    = rr_ptr;
        grant_n     = grant;
        nss_n       = nss;
        data_n      = data;
        poll_cnt_n  = poll_cnt;
        rsp_data_n  = rsp_data;
        rsp_err_n   = rsp_err;
        req_ready_o = '0;

        if (xfer_en) begin
            if (!psel) begin
                psel_n    = 1'b1;
                penable_n = 1'b0;
                paddr_n   = xfer_addr;
                pwrite_n  = xfer_wr;
                pwdata_n  = xfer_wdata;
            end else if (!penable) begin
                penable_n = 1'b1;
            end else if (done) begin
                psel_n    = 1'b0;
                penable_n = 1'b0;
                if (state == S_INIT_C1) begin
                    state_n = S_INIT_DIV;
                end else if (state == S_INIT_DIV) begin
                    state_n = S_IDLE;
                end else if (pslverr_i) begin
                    state_n    = S_RESP;
                    rsp_err_n  = 1'b1;
                    rsp_data_n = 32'd0;
                end else begin
                    case (state)
                        S_SET_CS: state_n = S_WR_TX;
                        S_WR_TX:  state_n = S_WR_TRL;
                        S_WR_TRL: state_n = S_START;
                        S_START:  state_n = S_POLL;
                        S_POLL: begin
                            if (!prdata_i[3]) begin
                                state_n = S_RD_RX;
                            end else if (poll_cnt + CW'(1) == CW'(POLL_MAX)) begin
                                state_n    = S_RESP;
                                rsp_err_n  = 1'b1;
                                rsp_data_n = 32'd0;
                            end else begin
                                poll_cnt_n = poll_cnt + CW'(1);
                            end
                        end
                        S_RD_RX: begin
                            state_n    = S_RESP;
                            rsp_err_n  = 1'b0;
                            rsp_data_n = prdata_i;
                        end
                        default: state_n = S_IDLE;
                    endcase
                end
            end
        end else if (state == S_IDLE) begin
            if (gnt_any && !rst_i) begin
                req_ready_o[gnt_idx] = 1'b1;
                grant_n  = gnt_idx;
                nss_n    = req_nss_i[int'(gnt_idx) * 4 +: 4];
                data_n   = req_data_i[int'(gnt_idx) * 32 +: 32];
                rr_ptr_n = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
                state_n  = S_SET_CS;
            end
        end else if (state == S_RESP) begin
            poll_cnt_n = '0;
            state_n    = S_IDLE;
        end
    end

    // State and registered APB/response outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_INIT_C1;
            psel     <= 1'b0;
            penable  <= 1'b0;
            pwrite   <= 1'b0;
            paddr    <= 32'd0;
            pwdata   <= 32'd0;
            rr_ptr   <= '0;
            grant    <= '0;
            nss      <= 4'd0;
            data     <= 32'd0;
            poll_cnt <= '0;
            rsp_data <= 32'd0;
            rsp_err  <= 1'b0;
        end else begin
            state    <= state_n;
            psel     <= psel_n;
            penable  <= penable_n;
            pwrite   <= pwrite_n;
            paddr    <= paddr_n;
            pwdata   <= pwdata_n;
            rr_ptr   <= rr_ptr_n;
            grant    <= grant_n;
            nss      <= nss_n;
            data     <= data_n;
            poll_cnt <= poll_cnt_n;
            rsp_data <= rsp_data_n;
            rsp_err  <= rsp_err_n;
        end
    end

    assign rsp_valid_o = (state == S_RESP && !rst_i) ? (NUM_REQ'(1) << grant) : '0;
    assign rsp_data_o  = rsp_data;
    assign rsp_err_o   = rsp_err;
    assign busy_o      = !rst_i && (state != S_IDLE);
    assign paddr_o     = paddr;
    assign psel_o      = psel;
    assign penable_o   = penable;
    assign pwrite_o    = pwrite;
    assign pwdata_o    = pwdata;
endmodule

// File: tb/tb_spi_req_sched.sv
// Bench for spi_req_sched: APB slave model plus a transaction-level model of
// the expected APB sequence, grants and responses, checked every cycle.
module tb_spi_req_sched;
    localparam int N    = 4;
    localparam int PMAX = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      cfg_ctrl1, cfg_div;
    logic [N-1:0]    req_valid, req_ready, rsp_valid;
    logic [N*4-1:0]  req_nss;
    logic [N*32-1:0] req_data;
    logic [31:0]     rsp_data, paddr, pwdata, prdata;
    logic            rsp_err, busy, psel, penable, pwrite, pready, pslverr;

    always #5 clk = ~clk;

    spi_req_sched #(.NUM_REQ(N), .POLL_MAX(PMAX)) dut (
        .clk_i(clk), .rst_i(rst), .cfg_ctrl1_i(cfg_ctrl1), .cfg_div_i(cfg_div),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_nss_i(req_nss),
        .req_data_i(req_data), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
        .rsp_err_o(rsp_err), .busy_o(busy), .paddr_o(paddr), .psel_o(psel),
        .penable_o(penable), .pwrite_o(pwrite), .pwdata_o(pwdata),
        .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
    );

    typedef struct { logic [31:0] addr; logic wr; logic [31:0] data; } txn_t;
    typedef struct { int cl; logic [31:0] data; logic err; } rsp_t;

    txn_t exp_t[$], tlog[$];
    rsp_t exp_r[$];
    int   tcyc[$], alog[$], glog[$];
    int   ncmp = 0, nbad = 0, cyc = 0;

    // slave / scenario knobs
    int          busy_polls, err_addr, wait_addr, wait_n, wait_left, busy_left, acc_len;
    logic [31:0] rx_word, hold_wd;
    int          rr_m, g;
    logic        prev_rdy;
    logic [N-1:0] last_rv;
    logic [31:0]  last_rd;
    logic         last_re;
    txn_t         et;
    rsp_t         er;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected APB script and response for a granted client, derived from
    // the slave knobs in force at grant time.
    task automatic model_req(input int c);
        txn_t s[$];
        logic [3:0] ns;
        int np;
        ns = req_nss[c*4 +: 4];
        s.push_back('{32'h04, 1'b1, {23'd0, 1'b0, ns, 4'b0100}});
        s.push_back('{32'h10, 1'b1, req_data[c*32 +: 32]});
        s.push_back('{32'h0C, 1'b1, 32'd1});
        s.push_back('{32'h04, 1'b1, {23'd0, 1'b0, ns, 4'b1100}});
        foreach (s[i]) begin
            exp_t.push_back(s[i]);
            if (s[i].addr == err_addr) begin exp_r.push_back('{c, 32'd0, 1'b1}); return; end
        end
        np = (busy_polls >= PMAX) ? PMAX : busy_polls + 1;
        repeat (np) exp_t.push_back('{32'h04, 1'b0, 32'd0});
        if (busy_polls >= PMAX) begin exp_r.push_back('{c, 32'd0, 1'b1}); return; end
        exp_t.push_back('{32'h14, 1'b0, 32'd0});
        if (err_addr == 'h14) exp_r.push_back('{c, 32'd0, 1'b1});
        else                  exp_r.push_back('{c, rx_word, 1'b0});
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Slave drive and per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            pready = 1'b0; pslverr = 1'b0; prdata = 32'd0;
            acc_len = 0; wait_left = 0; busy_left = 0; prev_rdy = 1'b0;
        end else begin
            if (req_ready !== '0) begin
                g = -1;
                for (int k = N - 1; k >= 0; k--) if (req_valid[(rr_m + k) % N]) g = (rr_m + k) % N;
                chk("ready_1cyc", {31'd0, prev_rdy}, 32'd0);
                chk("grant", {28'd0, req_ready}, (g < 0) ? 32'd0 : (32'd1 << g));
                if (g >= 0) begin
                    glog.push_back(g);
                    rr_m = (g + 1) % N;
                    model_req(g);
                end
            end
            prev_rdy = (req_ready !== '0);

            if (rsp_valid !== '0) begin
                last_rv = rsp_valid; last_rd = rsp_data; last_re = rsp_err;
                if (exp_r.size() == 0) chk("rsp_unexpected", {28'd0, rsp_valid}, 32'd0);
                else begin
                    er = exp_r.pop_front();
                    chk("rsp_client", {28'd0, rsp_valid}, 32'd1 << er.cl);
                    chk("rsp_data", rsp_data, er.data);
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, er.err});
                end
            end

            pslverr = 1'b0;
            if (psel && !penable) begin
                hold_wd   = pwdata;
                wait_left = (paddr == wait_addr) ? wait_n : 0;
                pready    = 1'b0;
            end else if (psel && penable) begin
                chk("pwdata_hold", pwdata, hold_wd);
                acc_len++;
                if (wait_left > 0) begin
                    pready = 1'b0;
                    wait_left--;
                end else begin
                    pready  = 1'b1;
                    pslverr = (paddr == err_addr);
                    prdata  = 32'd0;
                    if (paddr == 32'h04 && !pwrite) begin
                        prdata = (busy_left > 0) ? 32'h2C : 32'h24;
                        if (busy_left > 0) busy_left--;
                    end
                    if (paddr == 32'h14 && !pwrite) prdata = rx_word;
                    if (paddr == 32'h04 && pwrite && !pwdata[3]) busy_left = busy_polls;
                    tlog.push_back('{paddr, pwrite, pwdata});
                    tcyc.push_back(cyc);
                    alog.push_back(acc_len);
                    acc_len = 0;
                    if (exp_t.size() == 0) chk("apb_unexpected", paddr, 32'hFFFF_FFFF);
                    else begin
                        et = exp_t.pop_front();
                        chk("apb_addr", paddr, et.addr);
                        chk("apb_write", {31'd0, pwrite}, {31'd0, et.wr});
                        if (et.wr) chk("apb_wdata", pwdata, et.data);
                    end
                end
            end else begin
                pready = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        for (k = 0; k < 400; k++) begin
            tick();
            if (!busy && exp_t.size() == 0 && exp_r.size() == 0) break;
        end
        chk({"idle_", nm}, {31'd0, k < 400}, 32'd1);
        chk({"busy_", nm}, {31'd0, busy}, 32'd0);
    endtask

    task automatic send(input int c, input logic [3:0] ns, input logic [31:0] d);
        int k, g0;
        g0 = glog.size();
        req_nss[c*4 +: 4] = ns; req_data[c*32 +: 32] = d; req_valid[c] = 1'b1;
        for (k = 0; k < 200 && glog.size() == g0; k++) tick();
        chk("grant_seen", {31'd0, glog.size() > g0}, 32'd1);
        req_valid[c] = 1'b0;
    endtask

    task automatic do_init();
        exp_t.push_back('{32'h00, 1'b1, {24'd0, cfg_ctrl1}});
        exp_t.push_back('{32'h08, 1'b1, {24'd0, cfg_div}});
        rst = 1'b0;
        wait_idle("init");
    endtask

    function automatic int count_addr(input int from, input logic [31:0] a, input logic wr);
        int n = 0;
        for (int i = from; i < tlog.size(); i++) if (tlog[i].addr == a && tlog[i].wr == wr) n++;
        return n;
    endfunction

    initial begin
        int t0, g0, k, exp_g[5];
        rst = 1'b1; req_valid = 4'b0001; req_nss = '0; req_data = '0;
        cfg_ctrl1 = 8'h35; cfg_div = 8'h07;
        pready = 1'b0; prdata = 32'd0; pslverr = 1'b0;
        busy_polls = 0; err_addr = 'h08; wait_addr = -1; wait_n = 0; rx_word = 32'd0; rr_m = 0;
        repeat (3) tick();
        chk("rst_psel", {31'd0, psel}, 32'd0);
        chk("rst_penable", {31'd0, penable}, 32'd0);
        chk("rst_pwrite", {31'd0, pwrite}, 32'd0);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        chk("rst_rsp", {rsp_data[30:0], rsp_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        req_valid = '0;

        // Init, with pslverr on the DIV write that must be ignored.
        do_init();
        chk("init_c1", tlog[0].data, 32'h35);
        chk("init_div", tlog[1].data, 32'h07);
        chk("init_spacing", tcyc[1] - tcyc[0], 32'd3);
        err_addr = -1;

        // All four held: strict round robin from pointer 0.
        rx_word = 32'h77; g0 = glog.size();
        for (int c = 0; c < N; c++) begin
            req_nss[c*4 +: 4] = 4'(1 << c); req_data[c*32 +: 32] = 32'h100 + c;
        end
        req_valid = '1;
        for (k = 0; k < 3000 && glog.size() < g0 + 5; k++) tick();
        req_valid = '0;
        chk("rr_count", glog.size() - g0, 32'd5);
        exp_g = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5 && g0 + i < glog.size(); i++) chk("rr_order", glog[g0+i], exp_g[i]);
        wait_idle("rr");

        // Single request, two busy polls then done.
        busy_polls = 2; rx_word = 32'h5A; t0 = tlog.size();
        send(1, 4'b0010, 32'hA5);
        wait_idle("req1");
        chk("req1_ctrl2", tlog[t0].data, 32'h024);
        chk("req1_start", tlog[t0+3].data, 32'h02C);
        chk("req1_polls", count_addr(t0, 32'h04, 1'b0), 32'd3);
        chk("req1_rsp_v", {28'd0, last_rv}, 32'b0010);
        chk("req1_rsp_d", last_rd, 32'h5A);
        chk("req1_rsp_e", {31'd0, last_re}, 32'd0);

        // Wait states on the TX push.
        busy_polls = 0; wait_addr = 'h10; wait_n = 5; t0 = tlog.size();
        send(3, 4'b1000, 32'hCAFE_0001);
        wait_idle("wait");
        chk("wait_len", alog[t0+1], 32'd6);
        wait_addr = -1;

        // Slave error on the length write aborts before START.
        err_addr = 'h0C; t0 = tlog.size();
        send(0, 4'b0001, 32'h1234);
        wait_idle("slverr");
        chk("slverr_last", tlog[tlog.size()-1].addr, 32'h0C);
        chk("slverr_rsp", {last_rd[30:0], last_re}, 32'd1);
        err_addr = -1;

        // Status stuck busy: POLL_MAX polls then timeout error.
        busy_polls = 100; t0 = tlog.size();
        send(2, 4'b0100, 32'h55);
        wait_idle("timeout");
        chk("timeout_polls", count_addr(t0, 32'h04, 1'b0), 32'd4);
        chk("timeout_no_rx", count_addr(t0, 32'h14, 1'b0), 32'd0);
        chk("timeout_err", {31'd0, last_re}, 32'd1);
        busy_polls = 0;

        // Reset in the middle of a request sequence.
        send(1, 4'b0010, 32'h99);
        repeat (6) tick();
        rst = 1'b1; exp_t.delete(); exp_r.delete(); rr_m = 0;
        tick();
        chk("midrst_psel", {31'd0, psel}, 32'd0);
        chk("midrst_penable", {31'd0, penable}, 32'd0);
        t0 = tlog.size();
        do_init();
        chk("reinit_c1", tlog[t0].addr, 32'h00);

        // Recovery after reset.
        rx_word = 32'hBEEF;
        send(3, 4'b1000, 32'h42);
        wait_idle("after");
        chk("after_rsp", last_rd, 32'hBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
